// File: rtl/wb_stage_params_pkg.sv
// Shared types and helpers for the writeback/retire stage.
// Lane and port payloads are sized for register data up to WB_DATA_W bits.
package wb_stage_params;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_REG_W  = 5;

  typedef struct packed {
    logic [WB_DATA_W-1:0] pc;
    logic                 we;
    logic [WB_REG_W-1:0]  waddr;
    logic [WB_DATA_W-1:0] wdata;
    logic                 exc;
  } WBLaneData;

  typedef struct packed {
    logic                 we;
    logic [WB_REG_W-1:0]  waddr;
    logic [WB_DATA_W-1:0] wdata;
  } WBPortWrite;

  // Number of cycles needed to drain a bundle through the register-file ports.
  function automatic int unsigned wb_beats(input int unsigned lanes, input int unsigned ports);
    return (lanes + ports - 1) / ports;
  endfunction

endpackage

// File: rtl/wb_port_select.sv
// Maps the lanes of the current beat onto register-file write ports and
// drops the older of two same-beat writes to one nonzero register.
module wb_port_select
  import wb_stage_params::*;
#(
  parameter int unsigned LANES    = 2,
  parameter int unsigned RF_PORTS = 1,
  parameter int unsigned BEAT_W   = 1
) (
  input  logic                            active,
  input  logic [BEAT_W-1:0]               beat,
  input  WBLaneData [LANES-1:0]           lanes,
  input  logic [LANES-1:0]                lane_ok,
  output WBPortWrite [RF_PORTS-1:0]       port_wr,
  output logic [RF_PORTS-1:0][WB_DATA_W-1:0] port_pc
);

  WBPortWrite [RF_PORTS-1:0] sel;

  // Lane mux: port p in beat b carries lane b*RF_PORTS+p; absent lanes never write.
  always_comb begin
    sel     = '0;
    port_pc = '0;
    for (int p = 0; p < int'(RF_PORTS); p++) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (int'(beat) * int'(RF_PORTS) + p == l) begin
          sel[p].we    = active & lane_ok[l] & lanes[l].we;
          sel[p].waddr = lanes[l].waddr;
          sel[p].wdata = lanes[l].wdata;
          port_pc[p]   = lanes[l].pc;
        end
      end
    end
  end

  // Younger (higher) lane wins a same-beat collision on a nonzero register.
  always_comb begin
    port_wr = sel;
    for (int p = 0; p < int'(RF_PORTS); p++) begin
      for (int q = p + 1; q < int'(RF_PORTS); q++) begin
        if (sel[p].we && sel[q].we && (sel[p].waddr == sel[q].waddr) && (sel[p].waddr != '0)) begin
          port_wr[p].we = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: holds one bundle and drains it over BEATS cycles.
// Optional precise-exception support is enabled with WB_EXCEPTION_EN.
module wb_retire_stage
  import wb_stage_params::*;
#(
  parameter int unsigned LANES      = 2,
  parameter int unsigned RF_PORTS   = 1,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  output logic                           wb_allow_in,
  input  logic                           in_valid,
  input  logic [LANES-1:0]               in_lane_valid,
  input  logic [LANES*DATA_WIDTH-1:0]    in_pc,
  input  logic [LANES*DATA_WIDTH-1:0]    in_wdata,
  input  logic [LANES-1:0]               in_we,
  input  logic [LANES*5-1:0]             in_waddr,
`ifdef WB_EXCEPTION_EN
  input  logic [LANES-1:0]               in_exc,
  output logic                           flush,
  output logic [DATA_WIDTH-1:0]          flush_pc,
`endif
  output logic [RF_PORTS-1:0]            rf_we,
  output logic [RF_PORTS*5-1:0]          rf_waddr,
  output logic [RF_PORTS*DATA_WIDTH-1:0] rf_wdata,
  output logic [LANES*5-1:0]             bp_addr,
  output logic [LANES*DATA_WIDTH-1:0]    bp_data,
  output logic [RF_PORTS*DATA_WIDTH-1:0] debug_pc,
  output logic [RF_PORTS*4-1:0]          debug_we,
  output logic [RF_PORTS*5-1:0]          debug_waddr,
  output logic [RF_PORTS*DATA_WIDTH-1:0] debug_wdata
);

  localparam int unsigned BEATS  = wb_beats(LANES, RF_PORTS);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (DATA_WIDTH > WB_DATA_W || RF_PORTS > LANES || LANES > 4) begin : g_bad_cfg
    $error("wb_retire_stage: unsupported LANES/RF_PORTS/DATA_WIDTH combination");
  end

  logic                  wb_valid;
  logic [BEAT_W-1:0]     beat;
  logic [LANES-1:0]      hold_lane_valid;
  WBLaneData [LANES-1:0] hold;
  logic [LANES-1:0]      lane_exc_c;
  logic [LANES-1:0]      lane_kill;
  logic [LANES-1:0]      lane_ok;
  logic                  last_beat;
  logic                  accept;

  WBPortWrite [RF_PORTS-1:0]            port_wr;
  logic [RF_PORTS-1:0][WB_DATA_W-1:0]   port_pc;

`ifdef WB_EXCEPTION_EN
  assign lane_exc_c = in_exc;
`else
  assign lane_exc_c = '0;
`endif

  assign last_beat   = (beat == BEAT_W'(BEATS - 1));
  assign wb_allow_in = !wb_valid || last_beat;
  assign accept      = in_valid && wb_allow_in;

  // Control: a new bundle restarts at beat 0; the last beat either empties or reloads.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid <= 1'b0;
      beat     <= '0;
    end else if (accept) begin
      wb_valid <= 1'b1;
      beat     <= '0;
    end else if (wb_valid) begin
      if (last_beat) begin
        wb_valid <= 1'b0;
        beat     <= '0;
      end else begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      hold_lane_valid <= in_lane_valid;
      for (int l = 0; l < int'(LANES); l++) begin
        hold[l].pc    <= WB_DATA_W'(in_pc[l*DATA_WIDTH +: DATA_WIDTH]);
        hold[l].we    <= in_we[l];
        hold[l].waddr <= in_waddr[l*5 +: 5];
        hold[l].wdata <= WB_DATA_W'(in_wdata[l*DATA_WIDTH +: DATA_WIDTH]);
        hold[l].exc   <= lane_exc_c[l];
      end
    end
  end

  // The lowest excepting lane and every younger lane are squashed.
  always_comb begin
    lane_kill = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      lane_kill[l] = hold[l].exc;
      if (l > 0 && lane_kill[l-1]) lane_kill[l] = 1'b1;
    end
    lane_ok = hold_lane_valid & ~lane_kill;
  end

  wb_port_select #(
    .LANES    (LANES),
    .RF_PORTS (RF_PORTS),
    .BEAT_W   (BEAT_W)
  ) u_port_select (
    .active  (wb_valid),
    .beat    (beat),
    .lanes   (hold),
    .lane_ok (lane_ok),
    .port_wr (port_wr),
    .port_pc (port_pc)
  );

  always_comb begin
    rf_we       = '0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    debug_pc    = '0;
    debug_we    = '0;
    for (int p = 0; p < int'(RF_PORTS); p++) begin
      rf_we[p]                           = port_wr[p].we;
      rf_waddr[p*5 +: 5]                 = port_wr[p].waddr;
      rf_wdata[p*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(port_wr[p].wdata);
      debug_we[p*4 +: 4]                 = {4{port_wr[p].we}};
      debug_pc[p*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(port_pc[p]);
    end
  end

  assign debug_waddr = rf_waddr;
  assign debug_wdata = rf_wdata;

  // Back-pass advertises writes that have not reached the register file yet.
  always_comb begin
    bp_addr = '0;
    bp_data = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (wb_valid && lane_ok[l] && hold[l].we && (int'(beat) <= l / int'(RF_PORTS))) begin
        bp_addr[l*5 +: 5] = hold[l].waddr;
      end
      bp_data[l*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(hold[l].wdata);
    end
  end

`ifdef WB_EXCEPTION_EN
  // Flush fires once, in beat 0, carrying the PC of the lowest excepting lane.
  always_comb begin
    flush    = 1'b0;
    flush_pc = '0;
    for (int l = int'(LANES) - 1; l >= 0; l--) begin
      if (hold[l].exc) begin
        flush_pc = DATA_WIDTH'(hold[l].pc);
        flush    = wb_valid && (beat == '0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_retire_stage.sv
// Bench for wb_retire_stage: a 2-lane/1-port and a 2-lane/2-port instance.
// Exception checks are compiled in when WB_EXCEPTION_EN is defined.
module tb_wb_retire_stage;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance A: LANES=2, RF_PORTS=1
  logic        a_allow, a_valid;
  logic [1:0]  a_lv, a_we;
  logic [63:0] a_pc, a_wdata;
  logic [9:0]  a_waddr;
  logic [0:0]  a_rf_we;
  logic [4:0]  a_rf_waddr, a_dbg_waddr;
  logic [31:0] a_rf_wdata, a_dbg_pc, a_dbg_wdata;
  logic [9:0]  a_bp_addr;
  logic [63:0] a_bp_data;
  logic [3:0]  a_dbg_we;

  // Instance B: LANES=2, RF_PORTS=2
  logic        b_allow, b_valid;
  logic [1:0]  b_lv, b_we;
  logic [63:0] b_pc, b_wdata;
  logic [9:0]  b_waddr;
  logic [1:0]  b_rf_we;
  logic [9:0]  b_rf_waddr, b_dbg_waddr;
  logic [63:0] b_rf_wdata, b_dbg_pc, b_dbg_wdata;
  logic [9:0]  b_bp_addr;
  logic [63:0] b_bp_data;
  logic [7:0]  b_dbg_we;

`ifdef WB_EXCEPTION_EN
  logic [1:0]  a_exc, b_exc;
  logic        a_flush, b_flush;
  logic [31:0] a_flush_pc, b_flush_pc;
`endif

  wb_retire_stage #(.LANES(2), .RF_PORTS(1), .DATA_WIDTH(32)) u_a (
    .clock(clock), .reset(reset), .wb_allow_in(a_allow), .in_valid(a_valid),
    .in_lane_valid(a_lv), .in_pc(a_pc), .in_wdata(a_wdata), .in_we(a_we), .in_waddr(a_waddr),
`ifdef WB_EXCEPTION_EN
    .in_exc(a_exc), .flush(a_flush), .flush_pc(a_flush_pc),
`endif
    .rf_we(a_rf_we), .rf_waddr(a_rf_waddr), .rf_wdata(a_rf_wdata),
    .bp_addr(a_bp_addr), .bp_data(a_bp_data),
    .debug_pc(a_dbg_pc), .debug_we(a_dbg_we), .debug_waddr(a_dbg_waddr), .debug_wdata(a_dbg_wdata)
  );

  wb_retire_stage #(.LANES(2), .RF_PORTS(2), .DATA_WIDTH(32)) u_b (
    .clock(clock), .reset(reset), .wb_allow_in(b_allow), .in_valid(b_valid),
    .in_lane_valid(b_lv), .in_pc(b_pc), .in_wdata(b_wdata), .in_we(b_we), .in_waddr(b_waddr),
`ifdef WB_EXCEPTION_EN
    .in_exc(b_exc), .flush(b_flush), .flush_pc(b_flush_pc),
`endif
    .rf_we(b_rf_we), .rf_waddr(b_rf_waddr), .rf_wdata(b_rf_wdata),
    .bp_addr(b_bp_addr), .bp_data(b_bp_data),
    .debug_pc(b_dbg_pc), .debug_we(b_dbg_we), .debug_waddr(b_dbg_waddr), .debug_wdata(b_dbg_wdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic a_bundle(input logic [4:0] wa0, input logic [31:0] wd0, input logic [31:0] pc0,
                          input logic [4:0] wa1, input logic [31:0] wd1, input logic [31:0] pc1);
    a_lv    = 2'b11;
    a_we    = 2'b11;
    a_waddr = {wa1, wa0};
    a_wdata = {wd1, wd0};
    a_pc    = {pc1, pc0};
    a_valid = 1'b1;
  endtask

  typedef struct {
    logic [1:0]  lv;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [4:0]  wa1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [1:0]  exp_we;
    logic [9:0]  exp_bp;
  } vec_t;

  localparam int NV = 8;
  vec_t vt [NV];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'b11, 2'b11, 5'd1,  5'd2,  32'h100, 32'h200, 2'b11, {5'd2,  5'd1}};
    vt[1] = '{2'b11, 2'b11, 5'd5,  5'd5,  32'hA,   32'hB,   2'b10, {5'd5,  5'd5}};
    vt[2] = '{2'b11, 2'b11, 5'd0,  5'd0,  32'h1,   32'h2,   2'b11, {5'd0,  5'd0}};
    vt[3] = '{2'b10, 2'b11, 5'd7,  5'd8,  32'h77,  32'h88,  2'b10, {5'd8,  5'd0}};
    vt[4] = '{2'b11, 2'b10, 5'd9,  5'd10, 32'h99,  32'hAA,  2'b10, {5'd10, 5'd0}};
    vt[5] = '{2'b01, 2'b11, 5'd11, 5'd12, 32'hBB,  32'hCC,  2'b01, {5'd0,  5'd11}};
    vt[6] = '{2'b00, 2'b11, 5'd13, 5'd14, 32'hDD,  32'hEE,  2'b00, {5'd0,  5'd0}};
    vt[7] = '{2'b11, 2'b11, 5'd31, 5'd30, 32'hDEADBEEF, 32'hCAFEF00D, 2'b11, {5'd30, 5'd31}};

    reset = 1'b1;
    a_valid = 1'b0; a_lv = '0; a_we = '0; a_pc = '0; a_wdata = '0; a_waddr = '0;
    b_valid = 1'b0; b_lv = '0; b_we = '0; b_pc = '0; b_wdata = '0; b_waddr = '0;
`ifdef WB_EXCEPTION_EN
    a_exc = '0; b_exc = '0;
`endif
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst a allow", a_allow, 1'b1);
    chk("rst a rf_we", a_rf_we, 1'b0);
    chk("rst a dbg_we", a_dbg_we, 4'h0);
    chk("rst a bp_addr", a_bp_addr, 10'h0);
    chk("rst b allow", b_allow, 1'b1);
    chk("rst b rf_we", b_rf_we, 2'b00);
    chk("rst b dbg_we", b_dbg_we, 8'h00);
    chk("rst b bp_addr", b_bp_addr, 10'h0);
`ifdef WB_EXCEPTION_EN
    chk("rst b flush", b_flush, 1'b0);
`endif

    // Two-lane / one-port: lane0 then lane1 on consecutive cycles
    a_bundle(5'd3, 32'h11, 32'h1000, 5'd4, 32'h22, 32'h1004);
    tick();
    a_valid = 1'b0;
    chk("seq c1 rf_we", a_rf_we, 1'b1);
    chk("seq c1 waddr", a_rf_waddr, 5'd3);
    chk("seq c1 wdata", a_rf_wdata, 32'h11);
    chk("seq c1 allow", a_allow, 1'b0);
    chk("seq c1 bp_addr", a_bp_addr, {5'd4, 5'd3});
    chk("seq c1 dbg_pc", a_dbg_pc, 32'h1000);
    chk("seq c1 dbg_we", a_dbg_we, 4'hF);
    tick();
    chk("seq c2 rf_we", a_rf_we, 1'b1);
    chk("seq c2 waddr", a_rf_waddr, 5'd4);
    chk("seq c2 wdata", a_rf_wdata, 32'h22);
    chk("seq c2 allow", a_allow, 1'b1);
    chk("seq c2 bp_addr", a_bp_addr, {5'd4, 5'd0});
    chk("seq c2 dbg_pc", a_dbg_pc, 32'h1004);
    chk("seq c2 dbg_waddr", a_dbg_waddr, 5'd4);
    tick();
    chk("seq c3 rf_we", a_rf_we, 1'b0);
    chk("seq c3 bp_addr", a_bp_addr, 10'h0);

    // Back-to-back bundles with in_valid held high
    a_bundle(5'd1, 32'h1, 32'h3000, 5'd2, 32'h2, 32'h3004);
    tick();
    chk("b2b c1 waddr", a_rf_waddr, 5'd1);
    chk("b2b c1 allow", a_allow, 1'b0);
    a_bundle(5'd6, 32'h6, 32'h3008, 5'd7, 32'h7, 32'h300C);
    tick();
    chk("b2b c2 rf_we", a_rf_we, 1'b1);
    chk("b2b c2 waddr", a_rf_waddr, 5'd2);
    chk("b2b c2 allow", a_allow, 1'b1);
    tick();
    a_valid = 1'b0;
    chk("b2b c3 rf_we", a_rf_we, 1'b1);
    chk("b2b c3 waddr", a_rf_waddr, 5'd6);
    chk("b2b c3 wdata", a_rf_wdata, 32'h6);
    tick();
    chk("b2b c4 rf_we", a_rf_we, 1'b1);
    chk("b2b c4 waddr", a_rf_waddr, 5'd7);
    tick();
    chk("b2b c5 rf_we", a_rf_we, 1'b0);

    // Reset during beat 0 discards lane1
    a_bundle(5'd8, 32'h88, 32'h4000, 5'd9, 32'h99, 32'h4004);
    tick();
    a_valid = 1'b0;
    chk("rstmid c1 waddr", a_rf_waddr, 5'd8);
    reset = 1'b1;
    tick();
    chk("rstmid c2 rf_we", a_rf_we, 1'b0);
    chk("rstmid c2 allow", a_allow, 1'b1);
    chk("rstmid c2 bp_addr", a_bp_addr, 10'h0);
    chk("rstmid c2 dbg_we", a_dbg_we, 4'h0);
    reset = 1'b0;
    tick();
    chk("rstmid c3 rf_we", a_rf_we, 1'b0);

    // Two-lane / two-port: whole bundle retires in one cycle
    for (int i = 0; i < NV; i++) begin
      b_lv    = vt[i].lv;
      b_we    = vt[i].we;
      b_waddr = {vt[i].wa1, vt[i].wa0};
      b_wdata = {vt[i].wd1, vt[i].wd0};
      b_pc    = {32'h2004 + 32'(i * 8), 32'h2000 + 32'(i * 8)};
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      chk($sformatf("v%0d rf_we", i), b_rf_we, vt[i].exp_we);
      chk($sformatf("v%0d bp_addr", i), b_bp_addr, vt[i].exp_bp);
      chk($sformatf("v%0d dbg_we", i), b_dbg_we, {{4{vt[i].exp_we[1]}}, {4{vt[i].exp_we[0]}}});
      chk($sformatf("v%0d allow", i), b_allow, 1'b1);
      if (vt[i].exp_we[0]) begin
        chk($sformatf("v%0d p0 waddr", i), b_rf_waddr[4:0], vt[i].wa0);
        chk($sformatf("v%0d p0 wdata", i), b_rf_wdata[31:0], vt[i].wd0);
        chk($sformatf("v%0d p0 dbg_pc", i), b_dbg_pc[31:0], 32'h2000 + 32'(i * 8));
      end
      if (vt[i].exp_we[1]) begin
        chk($sformatf("v%0d p1 waddr", i), b_rf_waddr[9:5], vt[i].wa1);
        chk($sformatf("v%0d p1 wdata", i), b_rf_wdata[63:32], vt[i].wd1);
        chk($sformatf("v%0d p1 dbg_wdata", i), b_dbg_wdata[63:32], vt[i].wd1);
        chk($sformatf("v%0d p1 dbg_pc", i), b_dbg_pc[63:32], 32'h2004 + 32'(i * 8));
      end
    end
    tick();
    chk("b idle rf_we", b_rf_we, 2'b00);
    chk("b idle bp_addr", b_bp_addr, 10'h0);

`ifdef WB_EXCEPTION_EN
    // Lane1 excepts: lane0 writes, lane1 squashed, one-cycle flush
    b_lv    = 2'b11;
    b_we    = 2'b11;
    b_waddr = {5'd4, 5'd3};
    b_wdata = {32'h22, 32'h11};
    b_pc    = {32'hBFC00010, 32'hBFC0000C};
    b_exc   = 2'b10;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    b_exc   = 2'b00;
    chk("exc rf_we", b_rf_we, 2'b01);
    chk("exc p0 waddr", b_rf_waddr[4:0], 5'd3);
    chk("exc bp_addr", b_bp_addr, {5'd0, 5'd3});
    chk("exc flush", b_flush, 1'b1);
    chk("exc flush_pc", b_flush_pc, 32'hBFC00010);
    tick();
    chk("exc flush after", b_flush, 1'b0);
    chk("exc rf_we after", b_rf_we, 2'b00);
    chk("exc a flush", a_flush, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
